// File: rtl/sensor_reg_bank.sv
// Capture bank for inertial-sensor readback bytes: per-channel LSB-first word assembly
// with atomic commit, ready/overrun status and sequence/select error flags.
module sensor_reg_bank #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned BYTES_PER_CH = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_CH*BYTES_PER_CH-1:0]    wr_sel,
  input  logic [15:0]                       resp,
  input  logic [NUM_CH-1:0]                 rd_ack,
  input  logic                              err_clr,
  output logic [NUM_CH*8*BYTES_PER_CH-1:0]  data,
  output logic [NUM_CH-1:0]                 vld,
  output logic [NUM_CH-1:0]                 rdy,
  output logic [NUM_CH-1:0]                 ovr,
  output logic                              seq_err,
  output logic                              sel_err
);

  localparam int unsigned DATA_W   = 8 * BYTES_PER_CH;
  localparam int unsigned SEL_W    = NUM_CH * BYTES_PER_CH;
  localparam int unsigned LAST     = BYTES_PER_CH - 1;
  localparam int unsigned SH_BYTES = (BYTES_PER_CH > 1) ? BYTES_PER_CH - 1 : 1;
  localparam int unsigned IDX_W    = (BYTES_PER_CH > 1) ? $clog2(BYTES_PER_CH) : 1;

  logic [NUM_CH-1:0][DATA_W-1:0]     data_q,   data_d;
  logic [NUM_CH-1:0][SH_BYTES-1:0][7:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0][IDX_W-1:0]      idx_q,    idx_d;
  logic [NUM_CH-1:0]                 vld_q,    vld_d;
  logic [NUM_CH-1:0]                 rdy_q,    rdy_d;
  logic [NUM_CH-1:0]                 ovr_q,    ovr_d;
  logic                              seq_err_q, seq_err_d;
  logic                              sel_err_q, sel_err_d;

  logic [NUM_CH-1:0]        ovr_set;
  logic                     seq_set;
  logic                     sel_multi;
  logic [BYTES_PER_CH-1:0]  sel_c;
  logic [DATA_W-1:0]        word_c;
  logic                     commit_c;
  logic                     unused_resp_hi;

  assign unused_resp_hi = ^resp[15:8];

  always_comb begin
    data_d    = data_q;
    shadow_d  = shadow_q;
    idx_d     = idx_q;
    vld_d     = '0;
    rdy_d     = rdy_q;
    ovr_set   = '0;
    seq_set   = 1'b0;
    sel_c     = '0;
    word_c    = '0;
    commit_c  = 1'b0;
    // Any second bit set in the strobe voids the whole write.
    sel_multi = (wr_sel & (wr_sel - SEL_W'(1))) != '0;

    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      sel_c    = wr_sel[ch*BYTES_PER_CH +: BYTES_PER_CH];
      commit_c = 1'b0;
      word_c   = '0;
      if (!sel_multi) begin
        if (sel_c[LAST]) begin
          if (idx_q[ch] == IDX_W'(LAST)) begin
            commit_c = 1'b1;
          end else begin
            idx_d[ch] = '0;
            seq_set   = 1'b1;
          end
        end
        for (int unsigned b = 0; b < LAST; b++) begin
          if (sel_c[b]) begin
            if (idx_q[ch] == IDX_W'(b)) begin
              shadow_d[ch][b] = resp[7:0];
              idx_d[ch]       = IDX_W'(b + 1);
            end else if (b == 0) begin
              shadow_d[ch][0] = resp[7:0];
              idx_d[ch]       = IDX_W'(1);
              seq_set         = 1'b1;
            end else begin
              idx_d[ch] = '0;
              seq_set   = 1'b1;
            end
          end
        end
      end

      for (int unsigned bb = 0; bb < LAST; bb++) begin
        word_c[bb*8 +: 8] = shadow_q[ch][bb];
      end
      word_c[LAST*8 +: 8] = resp[7:0];

      // A commit in the same cycle as rd_ack keeps rdy: the ack belongs to the old word.
      if (commit_c) begin
        data_d[ch] = word_c;
        idx_d[ch]  = '0;
        vld_d[ch]  = 1'b1;
        rdy_d[ch]  = 1'b1;
        if (rdy_q[ch] && !rd_ack[ch]) ovr_set[ch] = 1'b1;
      end else if (rd_ack[ch]) begin
        rdy_d[ch] = 1'b0;
      end
    end

    ovr_d     = (ovr_q & ~{NUM_CH{err_clr}}) | ovr_set;
    seq_err_d = (seq_err_q & ~err_clr) | seq_set;
    sel_err_d = (sel_err_q & ~err_clr) | sel_multi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      shadow_q  <= '0;
      idx_q     <= '0;
      vld_q     <= '0;
      rdy_q     <= '0;
      ovr_q     <= '0;
      seq_err_q <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      shadow_q  <= shadow_d;
      idx_q     <= idx_d;
      vld_q     <= vld_d;
      rdy_q     <= rdy_d;
      ovr_q     <= ovr_d;
      seq_err_q <= seq_err_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign data    = data_q;
  assign vld     = vld_q;
  assign rdy     = rdy_q;
  assign ovr     = ovr_q;
  assign seq_err = seq_err_q;
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_sensor_reg_bank.sv
// Directed bench for sensor_reg_bank with NUM_CH=4, BYTES_PER_CH=2.
module tb_sensor_reg_bank;

  logic        clk;
  logic        rst_n;
  logic [7:0]  wr_sel;
  logic [15:0] resp;
  logic [3:0]  rd_ack;
  logic        err_clr;
  logic [63:0] data;
  logic [3:0]  vld;
  logic [3:0]  rdy;
  logic [3:0]  ovr;
  logic        seq_err;
  logic        sel_err;

  int unsigned errors = 0;
  int unsigned checks = 0;

  sensor_reg_bank #(.NUM_CH(4), .BYTES_PER_CH(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_sel  (wr_sel),
    .resp    (resp),
    .rd_ack  (rd_ack),
    .err_clr (err_clr),
    .data    (data),
    .vld     (vld),
    .rdy     (rdy),
    .ovr     (ovr),
    .seq_err (seq_err),
    .sel_err (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int unsigned ch, input int unsigned b, input logic [7:0] v);
    wr_sel = 8'(1 << (ch*2 + b));
    resp   = {8'hA5, v};
    tick();
    wr_sel = '0;
    resp   = '0;
  endtask

  function automatic logic [15:0] chd(input int unsigned ch);
    return data[ch*16 +: 16];
  endfunction

  initial begin
    rst_n = 1'b0; wr_sel = '0; resp = '0; rd_ack = '0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", data, 64'h0);
    chk("rst_vld", vld, 4'h0);
    chk("rst_rdy", rdy, 4'h0);
    chk("rst_ovr", ovr, 4'h0);
    chk("rst_seq", seq_err, 1'b0);
    chk("rst_sel", sel_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // basic two-byte commit on ch0
    wr(0, 0, 8'h34);
    chk("t1_partial_data", chd(0), 16'h0000);
    chk("t1_partial_vld", vld, 4'h0);
    wr(0, 1, 8'h12);
    chk("t1_data", chd(0), 16'h1234);
    chk("t1_vld", vld, 4'b0001);
    chk("t1_rdy", rdy, 4'b0001);
    tick();
    chk("t1_vld_pulse", vld, 4'h0);

    // interleaved channels
    wr(2, 0, 8'hCD);
    wr(1, 0, 8'h5A);
    wr(1, 1, 8'h5A);
    chk("t2_vld_ch1", vld, 4'b0010);
    wr(2, 1, 8'hAB);
    chk("t2_ch2", chd(2), 16'hABCD);
    chk("t2_ch1", chd(1), 16'h5A5A);
    chk("t2_seq", seq_err, 1'b0);
    chk("t2_rdy", rdy, 4'b0111);
    rd_ack = 4'b0111;
    tick();
    rd_ack = '0;
    chk("t2_ack_rdy", rdy, 4'b0000);

    // out-of-order byte dropped, then proper word
    wr(3, 1, 8'hFF);
    chk("t3_drop_data", chd(3), 16'h0000);
    chk("t3_drop_seq", seq_err, 1'b1);
    chk("t3_drop_vld", vld, 4'h0);
    wr(3, 0, 8'h01);
    wr(3, 1, 8'h02);
    chk("t3_ch3", chd(3), 16'h0201);
    chk("t3_vld", vld, 4'b1000);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t3_clr_seq", seq_err, 1'b0);

    // repeated byte0 restarts the word
    wr(1, 0, 8'h11);
    wr(1, 0, 8'h22);
    chk("t3r_seq", seq_err, 1'b1);
    wr(1, 1, 8'h33);
    chk("t3r_ch1", chd(1), 16'h3322);
    rd_ack = 4'b1010;
    err_clr = 1'b1;
    tick();
    rd_ack = '0;
    err_clr = 1'b0;
    chk("t3r_rdy", rdy, 4'b0000);
    chk("t3r_seq_clr", seq_err, 1'b0);

    // overrun
    wr(0, 0, 8'h01);
    wr(0, 1, 8'hAA);
    chk("t4_first_ovr", ovr, 4'h0);
    wr(0, 0, 8'h02);
    wr(0, 1, 8'hBB);
    chk("t4_ovr", ovr, 4'b0001);
    chk("t4_data", chd(0), 16'hBB02);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_ovr_clr", ovr, 4'h0);
    chk("t4_rdy_kept", rdy, 4'b0001);
    wr(0, 0, 8'h03);
    rd_ack = 4'b0001;
    wr(0, 1, 8'hCC);
    rd_ack = '0;
    chk("t4_ack_ovr", ovr, 4'h0);
    chk("t4_ack_rdy", rdy, 4'b0001);
    chk("t4_ack_data", chd(0), 16'hCC03);

    // multi-bit strobe ignored, idx preserved
    wr(0, 0, 8'h55);
    wr_sel = 8'b0000_0011;
    resp   = 16'h0077;
    tick();
    wr_sel = '0;
    resp   = '0;
    chk("t5_sel", sel_err, 1'b1);
    chk("t5_data", chd(0), 16'hCC03);
    chk("t5_vld", vld, 4'h0);
    wr(0, 1, 8'h66);
    chk("t5_resume", chd(0), 16'h6655);
    chk("t5_noseq", seq_err, 1'b0);
    chk("t5_ovr", ovr, 4'b0001);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t5_sel_clr", sel_err, 1'b0);
    chk("t5_ovr_clr", ovr, 4'h0);

    // error event beats err_clr in the same cycle
    err_clr = 1'b1;
    wr(3, 1, 8'h09);
    err_clr = 1'b0;
    chk("t5_err_wins", seq_err, 1'b1);
    chk("t5_ch3_kept", chd(3), 16'h0201);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t5_seq_clr", seq_err, 1'b0);

    // asynchronous reset mid-assembly
    wr(1, 0, 8'hEE);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_data", data, 64'h0);
    chk("t6_rst_rdy", rdy, 4'h0);
    chk("t6_rst_flags", {ovr, seq_err, sel_err, vld}, 10'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    wr(1, 1, 8'hFF);
    chk("t6_seq", seq_err, 1'b1);
    chk("t6_vld", vld, 4'h0);
    chk("t6_data", data, 64'h0);
    chk("t6_rdy", rdy, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
